// File: rtl/pe_axil_reg_slave_if.sv
// AXI4-Lite bus bundle between the PE master path and the register-bank responder.
interface pe_axil_reg_slave_if;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/pe_axil_reg_slave.sv
// AXI4-Lite responder over a bank of 32-bit registers; index 0 is a read-only ID.
// Exposes register contents and one-cycle per-register write pulses to PE logic.
module pe_axil_reg_slave #(
  parameter int unsigned N_REGS    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5045_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  pe_axil_reg_slave_if.slave    s_axil,
  output logic [N_REGS*32-1:0]  regs_flat,
  output logic [N_REGS-1:0]     wr_pulse
);

  localparam int unsigned IdxW       = $clog2(N_REGS);
  localparam logic [31:0] BankBytes  = 32'(N_REGS * 4);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  logic [31:0]      r_regs [1:N_REGS-1];
  logic             r_aw_held;
  logic [31:0]      r_awaddr;
  logic             r_w_held;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic [N_REGS-1:0] r_wr_pulse;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic [31:0]      w_aw_off;
  logic             w_aw_in_range;
  logic [IdxW-1:0]  w_aw_idx;
  logic             w_wr_ok;
  logic             w_commit;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic [31:0]      w_ar_off;
  logic             w_ar_in_range;
  logic [IdxW-1:0]  w_ar_idx;
  logic [31:0]      w_ar_data;
  logic             w_ar_hs;

  // Decode always works on the offset so addresses below BASE_ADDR wrap out of range.
  assign w_aw_off      = r_awaddr - BASE_ADDR;
  assign w_aw_in_range = (w_aw_off < BankBytes);
  assign w_aw_idx      = w_aw_off[IdxW+1:2];
  assign w_wr_ok       = w_aw_in_range && (w_aw_idx != '0);

  assign w_ar_off      = s_axil.s_araddr - BASE_ADDR;
  assign w_ar_in_range = (w_ar_off < BankBytes);
  assign w_ar_idx      = w_ar_off[IdxW+1:2];

  assign w_aw_hs  = s_axil.s_awvalid && !r_aw_held;
  assign w_w_hs   = s_axil.s_wvalid && !r_w_held;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign w_ar_hs  = s_axil.s_arvalid && !r_rvalid;

  assign s_axil.s_awready = !r_aw_held;
  assign s_axil.s_wready  = !r_w_held;
  assign s_axil.s_bvalid  = r_bvalid;
  assign s_axil.s_bresp   = r_bresp;
  assign s_axil.s_arready = !r_rvalid;
  assign s_axil.s_rvalid  = r_rvalid;
  assign s_axil.s_rdata   = r_rdata;
  assign s_axil.s_rresp   = r_rresp;
  assign wr_pulse         = r_wr_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held  <= 1'b0;
      r_awaddr   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RespOkay;
      r_wr_pulse <= '0;
      for (int k = 1; k < N_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      r_wr_pulse <= '0;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil.s_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil.s_wdata;
        r_wstrb  <= s_axil.s_wstrb;
      end
      if (r_bvalid && s_axil.s_bready) begin
        r_bvalid <= 1'b0;
      end
      // Holds cannot be refilled on the commit edge since both readies are low then.
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? RespOkay : RespSlvErr;
        for (int k = 1; k < N_REGS; k++) begin
          if (w_wr_ok && (w_aw_idx == IdxW'(k))) begin
            r_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (r_wstrb[b]) begin
                r_regs[k][8*b +: 8] <= r_wdata[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_ar_data = ID_VALUE;
    for (int k = 1; k < N_REGS; k++) begin
      if (w_ar_idx == IdxW'(k)) begin
        w_ar_data = r_regs[k];
      end
    end
  end

  // Same-edge read and commit: the read samples the register before the write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RespOkay;
    end else begin
      if (r_rvalid && s_axil.s_rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ar_in_range ? w_ar_data : '0;
        r_rresp  <= w_ar_in_range ? RespOkay : RespSlvErr;
      end
    end
  end

  always_comb begin
    regs_flat       = '0;
    regs_flat[31:0] = ID_VALUE;
    for (int k = 1; k < N_REGS; k++) begin
      regs_flat[32*k +: 32] = r_regs[k];
    end
  end

endmodule

// File: tb/tb_pe_axil_reg_slave.sv
// Scoreboard bench for pe_axil_reg_slave: a register model predicts responses and contents.
module tb_pe_axil_reg_slave;
  localparam int unsigned NRegs  = 16;
  localparam logic [31:0] Base   = 32'h0000_1000;
  localparam logic [31:0] IdVal  = 32'h5045_0001;
  localparam logic [1:0]  Okay   = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NRegs*32-1:0]    regs_flat;
  logic [NRegs-1:0]       wr_pulse;

  pe_axil_reg_slave_if bus ();

  pe_axil_reg_slave #(
    .N_REGS    (NRegs),
    .BASE_ADDR (Base),
    .ID_VALUE  (IdVal)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axil    (bus),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mdl   [NRegs];
  int          epcnt [NRegs];
  int          pcnt  [NRegs];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  always @(negedge clk) begin
    for (int k = 0; k < NRegs; k++) if (wr_pulse[k] === 1'b1) pcnt[k]++;
  end

  // Model: updates expected contents and queues the expected write response.
  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] st);
    logic [31:0] off;
    int idx;
    off = a - Base;
    idx = int'(off[5:2]);
    if (off < 32'(NRegs * 4) && idx != 0) begin
      for (int b = 0; b < 4; b++) if (st[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      epcnt[idx]++;
      exp_b.push_back(Okay);
    end else begin
      exp_b.push_back(SlvErr);
    end
  endfunction

  function automatic void mdl_read(input logic [31:0] a);
    logic [31:0] off;
    int idx;
    off = a - Base;
    idx = int'(off[5:2]);
    if (off >= 32'(NRegs * 4)) exp_r.push_back({32'h0, SlvErr});
    else if (idx == 0)         exp_r.push_back({IdVal, Okay});
    else                       exp_r.push_back({mdl[idx], Okay});
  endfunction

  function automatic void mdl_reset();
    for (int k = 0; k < NRegs; k++) mdl[k] = '0;
    exp_b.delete();
    exp_r.delete();
  endfunction

  function automatic logic [NRegs*32-1:0] mdl_flat();
    logic [NRegs*32-1:0] f;
    f = '0;
    f[31:0] = IdVal;
    for (int k = 1; k < NRegs; k++) f[32*k +: 32] = mdl[k];
    return f;
  endfunction

  // Drivers: act #1 after a rising edge; bounded waits report tmo instead of hanging.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output int lat, output bit tmo);
    bit aw_done, w_done, aw_acc, w_acc;
    int n;
    aw_done = 0; w_done = 0; n = 0; tmo = 0; lat = 0; resp = '0;
    bus.s_awaddr = a; bus.s_awvalid = 1'b1;
    bus.s_wdata = d; bus.s_wstrb = st; bus.s_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_acc = bus.s_awvalid && bus.s_awready;
      w_acc  = bus.s_wvalid && bus.s_wready;
      @(posedge clk); #1;
      if (aw_acc) begin bus.s_awvalid = 1'b0; aw_done = 1; end
      if (w_acc)  begin bus.s_wvalid = 1'b0;  w_done = 1;  end
      n++;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin tmo = 1; return; end
    n = 0;
    while (bus.s_bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    lat = n;
    if (bus.s_bvalid !== 1'b1) begin tmo = 1; return; end
    resp = bus.s_bresp;
    if (bus.s_bready) begin @(posedge clk); #1; end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output bit tmo);
    bit acc;
    int n;
    acc = 0; n = 0; tmo = 0; lat = 0; d = '0; resp = '0;
    bus.s_araddr = a; bus.s_arvalid = 1'b1;
    while (!acc && n < 20) begin
      acc = bus.s_arvalid && bus.s_arready;
      @(posedge clk); #1;
      n++;
    end
    bus.s_arvalid = 1'b0;
    if (!acc) begin tmo = 1; return; end
    n = 0;
    while (bus.s_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    lat = n;
    if (bus.s_rvalid !== 1'b1) begin tmo = 1; return; end
    d = bus.s_rdata; resp = bus.s_rresp;
    if (bus.s_rready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b1; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    mdl_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_hs: got aw/w/ar/b/r=%b%b%b%b%b want 11100", bus.s_awready,
               bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid);
    end
    n_cmp++;
    if ({bus.s_bresp, bus.s_rresp, bus.s_rdata, wr_pulse} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got bresp=%b rresp=%b rdata=%h pulse=%h want all 0",
               bus.s_bresp, bus.s_rresp, bus.s_rdata, wr_pulse);
    end
    n_cmp++;
    if (regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want %h", regs_flat, mdl_flat());
    end
  endtask

  task automatic test_read_id();
    logic [31:0] addrs [3];
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    int lat;
    bit tmo;
    addrs[0] = Base; addrs[1] = Base + 32'h4; addrs[2] = Base + 32'h3;
    for (int i = 0; i < 3; i++) begin
      mdl_read(addrs[i]);
      axi_read(addrs[i], d, r, lat, tmo);
      e = exp_r.pop_front();
      n_cmp++;
      if (tmo || {d, r} !== e || lat != 0) begin
        n_fail++;
        $display("FAIL read_%h: got %h/%b lat=%0d tmo=%0d want %h/%b lat=0", addrs[i], d, r,
                 lat, tmo, e[33:2], e[1:0]);
      end
    end
  endtask

  task automatic test_write_full();
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [33:0] e;
    int lat;
    bit tmo;
    mdl_write(Base + 32'h8, 32'hA5A5_1234, 4'hF);
    axi_write(Base + 32'h8, 32'hA5A5_1234, 4'hF, r, lat, tmo);
    eb = exp_b.pop_front();
    n_cmp++;
    if (tmo || r !== eb || lat != 1) begin
      n_fail++;
      $display("FAIL wr_full_b: got %b lat=%0d tmo=%0d want %b lat=1", r, lat, tmo, eb);
    end
    n_cmp++;
    if (regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL wr_full_regs: got %h want %h", regs_flat, mdl_flat());
    end
    for (int k = 0; k < NRegs; k++) begin
      n_cmp++;
      if (pcnt[k] != epcnt[k]) begin
        n_fail++;
        $display("FAIL wr_full_pulse%0d: got %0d want %0d", k, pcnt[k], epcnt[k]);
      end
    end
    mdl_read(Base + 32'hB);
    axi_read(Base + 32'hB, d, r, lat, tmo);
    e = exp_r.pop_front();
    n_cmp++;
    if (tmo || {d, r} !== e) begin
      n_fail++;
      $display("FAIL wr_full_readback: got %h/%b tmo=%0d want %h/%b", d, r, tmo, e[33:2], e[1:0]);
    end
  endtask

  task automatic test_partial();
    logic [3:0]  strb [2];
    logic [1:0]  r, eb;
    int lat;
    bit tmo;
    strb[0] = 4'b0101; strb[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      mdl_write(Base + 32'h8, 32'hFFFF_FFFF, strb[i]);
      axi_write(Base + 32'h8, 32'hFFFF_FFFF, strb[i], r, lat, tmo);
      eb = exp_b.pop_front();
      n_cmp++;
      if (tmo || r !== eb) begin
        n_fail++;
        $display("FAIL partial_b%0d: got %b tmo=%0d want %b", i, r, tmo, eb);
      end
      n_cmp++;
      if (regs_flat[2*32 +: 32] !== mdl[2] || pcnt[2] != epcnt[2]) begin
        n_fail++;
        $display("FAIL partial_reg%0d: got %h pulses=%0d want %h pulses=%0d", i,
                 regs_flat[2*32 +: 32], pcnt[2], mdl[2], epcnt[2]);
      end
    end
  endtask

  task automatic test_same_edge();
    logic [1:0]  eb;
    logic [33:0] e;
    mdl_read(Base + 32'h8);
    mdl_write(Base + 32'h8, 32'h0BAD_F00D, 4'hF);
    bus.s_awaddr = Base + 32'h8; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h0BAD_F00D; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    bus.s_araddr = Base + 32'h8; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    e  = exp_r.pop_front();
    eb = exp_b.pop_front();
    n_cmp++;
    if ({bus.s_rvalid, bus.s_rdata, bus.s_rresp} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL same_edge_r: got v=%b %h/%b want v=1 %h/%b", bus.s_rvalid, bus.s_rdata,
               bus.s_rresp, e[33:2], e[1:0]);
    end
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp} !== {1'b1, eb} || regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL same_edge_w: got v=%b %b reg2=%h want v=1 %b reg2=%h", bus.s_bvalid,
               bus.s_bresp, regs_flat[2*32 +: 32], eb, mdl[2]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [1:0]  e1, e2;
    logic [31:0] old4;
    bus.s_bready = 1'b0;
    mdl_write(Base + 32'hC, 32'h1357_9BDF, 4'hF);
    bus.s_wdata = 32'h1357_9BDF; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.s_bvalid, bus.s_wready} !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_whold%0d: got bvalid=%b wready=%b want 0 0", i, bus.s_bvalid,
                 bus.s_wready);
      end
      @(posedge clk); #1;
    end
    bus.s_awaddr = Base + 32'hC; bus.s_awvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    n_cmp++;
    if (bus.s_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_early_b: got %b want 0", bus.s_bvalid);
    end
    @(posedge clk); #1;
    e1 = exp_b.pop_front();
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp} !== {1'b1, e1} || regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL stall_commit1: got v=%b %b reg3=%h want v=1 %b reg3=%h", bus.s_bvalid,
               bus.s_bresp, regs_flat[3*32 +: 32], e1, mdl[3]);
    end
    old4 = mdl[4];
    mdl_write(Base + 32'h10, 32'h2468_ACE0, 4'hF);
    bus.s_awaddr = Base + 32'h10; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'h2468_ACE0; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.s_bvalid, bus.s_bresp} !== {1'b1, e1} || regs_flat[4*32 +: 32] !== old4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b %b reg4=%h want v=1 %b reg4=%h", i,
                 bus.s_bvalid, bus.s_bresp, regs_flat[4*32 +: 32], e1, old4);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({bus.s_awready, bus.s_wready} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_holds_full: got awready=%b wready=%b want 0 0", bus.s_awready,
               bus.s_wready);
    end
    bus.s_bready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.s_bvalid !== 1'b0 || regs_flat[4*32 +: 32] !== old4) begin
      n_fail++;
      $display("FAIL stall_bhs: got v=%b reg4=%h want v=0 reg4=%h", bus.s_bvalid,
               regs_flat[4*32 +: 32], old4);
    end
    @(posedge clk); #1;
    e2 = exp_b.pop_front();
    n_cmp++;
    if ({bus.s_bvalid, bus.s_bresp} !== {1'b1, e2} || regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL stall_commit2: got v=%b %b reg4=%h want v=1 %b reg4=%h", bus.s_bvalid,
               bus.s_bresp, regs_flat[4*32 +: 32], e2, mdl[4]);
    end
    @(posedge clk); #1;
    for (int k = 3; k < 5; k++) begin
      n_cmp++;
      if (pcnt[k] != epcnt[k]) begin
        n_fail++;
        $display("FAIL stall_pulse%0d: got %0d want %0d", k, pcnt[k], epcnt[k]);
      end
    end
  endtask

  task automatic test_slverr();
    logic [31:0] wa [2];
    logic [31:0] ra [2];
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [33:0] e;
    int lat;
    bit tmo;
    wa[0] = Base; wa[1] = Base + 32'(NRegs * 4);
    ra[0] = Base + 32'(NRegs * 4); ra[1] = Base - 32'h4;
    for (int i = 0; i < 2; i++) begin
      mdl_write(wa[i], 32'hDEAD_BEEF, 4'hF);
      axi_write(wa[i], 32'hDEAD_BEEF, 4'hF, r, lat, tmo);
      eb = exp_b.pop_front();
      n_cmp++;
      if (tmo || r !== eb) begin
        n_fail++;
        $display("FAIL slverr_wr_%h: got %b tmo=%0d want %b", wa[i], r, tmo, eb);
      end
    end
    for (int i = 0; i < 2; i++) begin
      mdl_read(ra[i]);
      axi_read(ra[i], d, r, lat, tmo);
      e = exp_r.pop_front();
      n_cmp++;
      if (tmo || {d, r} !== e) begin
        n_fail++;
        $display("FAIL slverr_rd_%h: got %h/%b tmo=%0d want %h/%b", ra[i], d, r, tmo,
                 e[33:2], e[1:0]);
      end
    end
    n_cmp++;
    if (regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL slverr_regs: got %h want %h", regs_flat, mdl_flat());
    end
    for (int k = 0; k < NRegs; k++) begin
      n_cmp++;
      if (pcnt[k] != epcnt[k]) begin
        n_fail++;
        $display("FAIL slverr_pulse%0d: got %0d want %0d", k, pcnt[k], epcnt[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r, eb;
    logic [33:0] e;
    int lat;
    bit tmo;
    // Pending B response dropped by reset.
    bus.s_bready = 1'b0;
    bus.s_awaddr = Base + 32'h14; bus.s_awvalid = 1'b1;
    bus.s_wdata = 32'hCAFE_0014; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.s_bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_bsetup: got %b want 1", bus.s_bvalid);
    end
    rst = 1'b1;
    #1;
    mdl_reset();
    n_cmp++;
    if (bus.s_bvalid !== 1'b0 || regs_flat !== mdl_flat()) begin
      n_fail++;
      $display("FAIL rstmid_b: got v=%b regs=%h want v=0 regs=%h", bus.s_bvalid, regs_flat,
               mdl_flat());
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    bus.s_bready = 1'b1;
    // Pending R response dropped by reset.
    bus.s_rready = 1'b0;
    bus.s_araddr = Base + 32'h8; bus.s_arvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    n_cmp++;
    if (bus.s_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_rsetup: got %b want 1", bus.s_rvalid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_rvalid, bus.s_rdata, bus.s_rresp} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_r: got v=%b %h/%b want v=0 0/0", bus.s_rvalid, bus.s_rdata,
               bus.s_rresp);
    end
    @(negedge clk) rst = 1'b0;
    bus.s_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.s_bvalid, bus.s_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_stray%0d: got b=%b r=%b want 0 0", i, bus.s_bvalid, bus.s_rvalid);
      end
    end
    mdl_read(Base + 32'h8);
    axi_read(Base + 32'h8, d, r, lat, tmo);
    e = exp_r.pop_front();
    n_cmp++;
    if (tmo || {d, r} !== e) begin
      n_fail++;
      $display("FAIL rstmid_rd8: got %h/%b tmo=%0d want %h/%b", d, r, tmo, e[33:2], e[1:0]);
    end
    mdl_write(Base + 32'h14, 32'h7777_0014, 4'hF);
    axi_write(Base + 32'h14, 32'h7777_0014, 4'hF, r, lat, tmo);
    eb = exp_b.pop_front();
    n_cmp++;
    if (tmo || r !== eb || lat != 1) begin
      n_fail++;
      $display("FAIL rstmid_wr: got %b lat=%0d tmo=%0d want %b lat=1", r, lat, tmo, eb);
    end
    mdl_read(Base + 32'h14);
    axi_read(Base + 32'h14, d, r, lat, tmo);
    e = exp_r.pop_front();
    n_cmp++;
    if (tmo || {d, r} !== e) begin
      n_fail++;
      $display("FAIL rstmid_rd14: got %h/%b tmo=%0d want %h/%b", d, r, tmo, e[33:2], e[1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_write_full();
    test_partial();
    test_same_edge();
    test_stall();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
